// File: rtl/aes_prng_sched.sv
// Reseed/launch/completion sequencer for the masked AES core and its PRNG.
// Optional RUN watchdog is compiled in with `define AES_SCHED_WATCHDOG_EN.
module aes_prng_sched #(
    parameter int RESEED_PERIOD = 1024,
    parameter int CNT_W         = 16,
    parameter int WDOG_CYCLES   = 64
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [79:0]      seed_in,
    input  logic             seed_valid,
    output logic             seed_ready,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             aes_valid_in,
    input  logic             aes_ready,
    input  logic             aes_cipher_valid,
    output logic [79:0]      prng_seed,
    output logic             prng_start_reseed,
    output logic             prng_out_ready,
    input  logic             prng_out_valid,
    input  logic             prng_busy,
    output logic             need_seed,
    output logic [CNT_W-1:0] enc_count,
    output logic [1:0]       err
);

    // state     | meaning
    // SEED_WAIT | no valid seed; host must supply one
    // RS_START  | one-cycle reseed strobe to the PRNG
    // RS_WAIT   | PRNG reseeding; first cycle ignored
    // READY     | randomness valid, accepting requests or a voluntary seed
    // LAUNCH    | presenting the request to the core
    // RUN       | core busy encrypting
    // DONE      | ciphertext valid, waiting for host
    // ERR       | dropout or watchdog; only a new seed recovers
    typedef enum logic [2:0] {
        SEED_WAIT, RS_START, RS_WAIT, READY, LAUNCH, RUN, DONE, ERR
    } state_t;

    localparam logic [CNT_W-1:0] PERIOD_C = CNT_W'(RESEED_PERIOD);

    if (longint'(RESEED_PERIOD) < 0 || longint'(RESEED_PERIOD) >= (longint'(1) << CNT_W)) begin : g_bad_period
        $error("RESEED_PERIOD must lie in [0, 2**CNT_W)");
    end
    if (WDOG_CYCLES < 1) begin : g_bad_wdog
        $error("WDOG_CYCLES must be at least 1");
    end

    state_t           state, state_nx;
    logic             rs_seen;
    logic [79:0]      seed_q;
    logic [CNT_W-1:0] cnt_q, cnt_nx, cnt_inc;
    logic             err_rd, err_rd_nx;
    logic             err_wd;
    logic             wd_fire;

    assign seed_ready        = (state == SEED_WAIT) || (state == READY) || (state == ERR);
    assign in_ready          = (state == READY) && prng_out_valid && !(seed_valid && in_valid);
    assign out_valid         = (state == DONE);
    assign aes_valid_in      = (state == LAUNCH);
    assign prng_out_ready    = (state == LAUNCH) || (state == RUN);
    assign prng_start_reseed = (state == RS_START);
    assign need_seed         = (state == SEED_WAIT);
    assign prng_seed         = seed_q;
    assign enc_count         = cnt_q;
    assign err               = {err_wd, err_rd};

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt_q;
        err_rd_nx = err_rd;
        case (state)
            SEED_WAIT: begin
                if (seed_valid) begin
                    state_nx = RS_START;
                    cnt_nx   = '0;
                end
            end
            RS_START: state_nx = RS_WAIT;
            RS_WAIT: begin
                if (rs_seen && !prng_busy && prng_out_valid) state_nx = READY;
            end
            READY: begin
                // a pending seed always beats a pending request
                if (seed_valid) begin
                    state_nx = RS_START;
                    cnt_nx   = '0;
                end else if (in_valid && in_ready) begin
                    state_nx = LAUNCH;
                end
            end
            LAUNCH: begin
                if (!prng_out_valid) begin
                    state_nx  = ERR;
                    err_rd_nx = 1'b1;
                end else if (aes_ready) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (!prng_out_valid) begin
                    state_nx  = ERR;
                    err_rd_nx = 1'b1;
                end else if (aes_cipher_valid) begin
                    state_nx = DONE;
                end else if (wd_fire) begin
                    state_nx = ERR;
                end
            end
            DONE: begin
                if (out_ready) begin
                    cnt_nx = cnt_inc;
                    if (RESEED_PERIOD != 0 && cnt_inc == PERIOD_C) state_nx = SEED_WAIT;
                    else                                           state_nx = READY;
                end
            end
            ERR: begin
                if (seed_valid) begin
                    state_nx  = RS_START;
                    err_rd_nx = 1'b0;
                    cnt_nx    = '0;
                end
            end
            default: state_nx = SEED_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state   <= SEED_WAIT;
            rs_seen <= 1'b0;
            seed_q  <= '0;
            cnt_q   <= '0;
            err_rd  <= 1'b0;
        end else begin
            state   <= state_nx;
            rs_seen <= (state == RS_WAIT);
            cnt_q   <= cnt_nx;
            err_rd  <= err_rd_nx;
            if (seed_valid && seed_ready) seed_q <= seed_in;
        end
    end

`ifdef AES_SCHED_WATCHDOG_EN
    localparam int              WD_W    = $clog2(WDOG_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt;

    // fires on the edge that would bring the count to WDOG_CYCLES
    assign wd_fire = (state == RUN) && (wd_cnt == WD_LAST) && prng_out_valid && !aes_cipher_valid;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wd_cnt <= '0;
            err_wd <= 1'b0;
        end else begin
            if (state == RUN) wd_cnt <= wd_cnt + WD_W'(1);
            else              wd_cnt <= '0;
            if (wd_fire)                          err_wd <= 1'b1;
            else if (state == ERR && seed_valid)  err_wd <= 1'b0;
        end
    end
`else
    assign wd_fire = 1'b0;
    assign err_wd  = 1'b0;
`endif

endmodule

// File: tb/tb_aes_prng_sched.sv
// Directed bench for aes_prng_sched (RESEED_PERIOD=3); watchdog checks follow AES_SCHED_WATCHDOG_EN.
module tb_aes_prng_sched;

    logic        clk;
    logic        nrst;
    logic [79:0] seed_in;
    logic        seed_valid;
    logic        seed_ready;
    logic        in_valid;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic        aes_valid_in;
    logic        aes_ready;
    logic        aes_cipher_valid;
    logic [79:0] prng_seed;
    logic        prng_start_reseed;
    logic        prng_out_ready;
    logic        prng_out_valid;
    logic        prng_busy;
    logic        need_seed;
    logic [3:0]  enc_count;
    logic [1:0]  err;

    int total = 0;
    int bad   = 0;

    aes_prng_sched #(
        .RESEED_PERIOD(3),
        .CNT_W        (4),
        .WDOG_CYCLES  (64)
    ) dut (
        .clk              (clk),
        .nrst             (nrst),
        .seed_in          (seed_in),
        .seed_valid       (seed_valid),
        .seed_ready       (seed_ready),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .aes_valid_in     (aes_valid_in),
        .aes_ready        (aes_ready),
        .aes_cipher_valid (aes_cipher_valid),
        .prng_seed        (prng_seed),
        .prng_start_reseed(prng_start_reseed),
        .prng_out_ready   (prng_out_ready),
        .prng_out_valid   (prng_out_valid),
        .prng_busy        (prng_busy),
        .need_seed        (need_seed),
        .enc_count        (enc_count),
        .err              (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // seed handshake, then RS_START and two RS_WAIT cycles with an idle PRNG
    task automatic reseed(input logic [79:0] s);
        seed_in    = s;
        seed_valid = 1'b1;
        tick();
        seed_valid = 1'b0;
        repeat (3) tick();
    endtask

    // request from READY, core accepts after one LAUNCH cycle; returns in first RUN cycle
    task automatic launch();
        in_valid = 1'b1;
        tick();
        in_valid  = 1'b0;
        aes_ready = 1'b1;
        tick();
        aes_ready = 1'b0;
    endtask

    task automatic finish_enc(input int lat);
        repeat (lat - 1) tick();
        aes_cipher_valid = 1'b1;
        tick();
        aes_cipher_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        nrst = 1'b0;
        seed_in = '0;
        seed_valid = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        aes_ready = 1'b0;
        aes_cipher_valid = 1'b0;
        prng_out_valid = 1'b0;
        prng_busy = 1'b0;
        repeat (3) tick();

        chk("rst_need_seed", need_seed, 1);
        chk("rst_seed_ready", seed_ready, 1);
        chk("rst_prng_seed", prng_seed, 0);
        chk("rst_enc_count", enc_count, 0);
        chk("rst_err", err, 0);
        chk("rst_other_out", {in_ready, out_valid, aes_valid_in, prng_start_reseed, prng_out_ready}, 0);

        nrst = 1'b1;
        tick();

        // reset and reseed with a busy PRNG
        prng_busy      = 1'b1;
        prng_out_valid = 1'b0;
        seed_in        = 80'h1234;
        seed_valid     = 1'b1;
        tick();
        seed_valid = 1'b0;
        chk("seed_captured", prng_seed, 80'h1234);
        chk("reseed_strobe", prng_start_reseed, 1);
        chk("rs_need_seed", need_seed, 0);
        tick();
        chk("reseed_one_cycle", prng_start_reseed, 0);
        repeat (2) tick();
        chk("busy_holds", in_ready, 0);
        prng_busy      = 1'b0;
        prng_out_valid = 1'b1;
        tick();
        chk("ready_in_ready", in_ready, 1);
        chk("ready_seed_ready", seed_ready, 1);

        aes_cipher_valid = 1'b1;
        tick();
        aes_cipher_valid = 1'b0;
        chk("cv_ignored_ready", out_valid, 0);

        // single encryption, 21-cycle core latency, host stalls 5 cycles
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("launch_valid", aes_valid_in, 1);
        chk("launch_prng_rdy", prng_out_ready, 1);
        tick();
        chk("launch_hold", aes_valid_in, 1);
        aes_ready = 1'b1;
        tick();
        aes_ready = 1'b0;
        chk("run_valid_low", aes_valid_in, 0);
        chk("run_prng_rdy", prng_out_ready, 1);
        repeat (20) tick();
        chk("run_no_out", out_valid, 0);
        aes_cipher_valid = 1'b1;
        tick();
        aes_cipher_valid = 1'b0;
        chk("out_valid_rise", out_valid, 1);
        repeat (5) tick();
        chk("out_valid_hold", out_valid, 1);
        chk("count_before_hs", enc_count, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("out_valid_drop", out_valid, 0);
        chk("count_one", enc_count, 1);
        chk("done_to_ready", in_ready, 1);

        // seed and request together: seed wins
        seed_in    = 80'hABCD;
        seed_valid = 1'b1;
        in_valid   = 1'b1;
        #1;
        chk("sim_in_ready", in_ready, 0);
        tick();
        seed_valid = 1'b0;
        in_valid   = 1'b0;
        chk("sim_reseed", prng_start_reseed, 1);
        chk("sim_no_launch", aes_valid_in, 0);
        chk("sim_seed", prng_seed, 80'hABCD);
        chk("sim_count_clr", enc_count, 0);
        tick();
        chk("rswait_first", in_ready, 0);
        tick();
        chk("rswait_second", in_ready, 0);
        tick();
        chk("rswait_exit", in_ready, 1);

        // forced reseed after three encryptions
        launch();
        finish_enc(4);
        chk("forced_cnt1", enc_count, 1);
        launch();
        finish_enc(2);
        chk("forced_cnt2", enc_count, 2);
        chk("forced_no_seed2", need_seed, 0);
        chk("forced_rdy2", in_ready, 1);
        launch();
        finish_enc(1);
        chk("forced_need_seed", need_seed, 1);
        chk("forced_cnt3", enc_count, 3);
        chk("forced_in_ready", in_ready, 0);
        in_valid = 1'b1;
        repeat (3) tick();
        chk("forced_blocked", {in_ready, aes_valid_in}, 0);
        in_valid = 1'b0;
        reseed(80'h5555);
        chk("forced_resumed", in_ready, 1);
        chk("forced_cnt_clr", enc_count, 0);

        // randomness dropout in RUN, coinciding with cipher_valid
        launch();
        repeat (3) tick();
        prng_out_valid   = 1'b0;
        aes_cipher_valid = 1'b1;
        tick();
        aes_cipher_valid = 1'b0;
        prng_out_valid   = 1'b1;
        chk("drop_err", err, 2'b01);
        chk("drop_no_done", out_valid, 0);
        chk("drop_err_outs", {seed_ready, need_seed, in_ready, prng_out_ready, aes_valid_in}, 5'b10000);
        seed_in    = 80'h77;
        seed_valid = 1'b1;
        tick();
        seed_valid = 1'b0;
        chk("drop_err_clr", err, 0);
        chk("drop_reseed", prng_start_reseed, 1);
        repeat (3) tick();
        chk("drop_recovered", in_ready, 1);

        // asynchronous reset during LAUNCH
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("arst_pre", aes_valid_in, 1);
        #2 nrst = 1'b0;
        #1;
        chk("arst_outs", {aes_valid_in, prng_out_ready, need_seed}, 3'b001);
        chk("arst_seed", prng_seed, 0);
        tick();
        nrst = 1'b1;
        tick();
        reseed(80'h99);

        // withheld cipher_valid
        launch();
`ifdef AES_SCHED_WATCHDOG_EN
        repeat (63) tick();
        chk("wdog_not_yet", err, 0);
        chk("wdog_still_run", prng_out_ready, 1);
        tick();
        chk("wdog_err", err, 2'b10);
        chk("wdog_err_state", {seed_ready, prng_out_ready}, 2'b10);
`else
        repeat (100) tick();
        chk("nowd_err", err, 0);
        chk("nowd_run", prng_out_ready, 1);
        chk("nowd_no_out", out_valid, 0);
        aes_cipher_valid = 1'b1;
        tick();
        aes_cipher_valid = 1'b0;
        chk("nowd_done", out_valid, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
